// File: rtl/risk_cpu_if.sv
// Memory-side bus of the risk_cpu core: instruction fetch port and data port.
// master = core side, slave = memory side.
interface risk_cpu_if;
    logic        i_valid_i;
    logic        i_valid_d;
    logic [31:0] i_data_in_i;
    logic [31:0] i_data_in_d;
    logic [31:0] o_addr_i;
    logic [31:0] o_addr_d;
    logic [3:0]  o_we_d;
    logic        o_rd_d;
    logic [31:0] o_data_out_d;

    modport master (
        input  i_valid_i, i_valid_d, i_data_in_i, i_data_in_d,
        output o_addr_i, o_addr_d, o_we_d, o_rd_d, o_data_out_d
    );

    modport slave (
        output i_valid_i, i_valid_d, i_data_in_i, i_data_in_d,
        input  o_addr_i, o_addr_d, o_we_d, o_rd_d, o_data_out_d
    );
endinterface

// File: rtl/risk_cpu.sv
// risk_cpu: multi-cycle, non-pipelined RV32I core (FETCH -> EXEC [-> MEM]).
// Optional build macro CPU_ILLEGAL_HALT_EN: illegal instructions (and the
// halt address) park the core in HALT; without it illegal ops act as NOPs.
module risk_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    risk_cpu_if.master bus
);
    localparam logic [31:0] HALT_ADDR = 32'h0001_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [0:31];
    logic [31:0] addr_d_q;
    logic [31:0] data_out_q;
    logic [3:0]  we_q;
    logic        rd_q;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] pc_plus4;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign funct3   = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign funct7   = ir[31:25];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'd0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_v    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_v    = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    // Execute-stage results
    logic [31:0] ex_result;
    logic        ex_wr;
    logic [31:0] ex_next_pc;
    logic        ex_load;
    logic        ex_store;
    logic        ex_illegal;
    logic [31:0] ex_ea;
    logic [3:0]  ex_we;
    logic [31:0] ex_wdata;
    logic        br_taken;
    logic [4:0]  shamt;
    logic [31:0] op_b;

    // Decode and ALU: result, next PC, memory request and legality
    always_comb begin
        ex_result  = 32'd0;
        ex_wr      = 1'b0;
        ex_next_pc = pc_plus4;
        ex_load    = 1'b0;
        ex_store   = 1'b0;
        ex_illegal = 1'b0;
        ex_ea      = rs1_v + imm_i;
        ex_we      = 4'd0;
        ex_wdata   = 32'd0;
        br_taken   = 1'b0;
        op_b       = (opcode == OP_REG) ? rs2_v : imm_i;
        shamt      = (opcode == OP_REG) ? rs2_v[4:0] : rs2;
        case (opcode)
            OP_LUI: begin
                ex_result = imm_u;
                ex_wr     = 1'b1;
            end
            OP_AUIPC: begin
                ex_result = pc + imm_u;
                ex_wr     = 1'b1;
            end
            OP_JAL: begin
                ex_result  = pc_plus4;
                ex_wr      = 1'b1;
                ex_next_pc = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 != 3'b000) begin
                    ex_illegal = 1'b1;
                end else begin
                    ex_result  = pc_plus4;
                    ex_wr      = 1'b1;
                    ex_next_pc = (rs1_v + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  br_taken = (rs1_v == rs2_v);
                    3'b001:  br_taken = (rs1_v != rs2_v);
                    3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
                    3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
                    3'b110:  br_taken = (rs1_v < rs2_v);
                    3'b111:  br_taken = (rs1_v >= rs2_v);
                    default: ex_illegal = 1'b1;
                endcase
                if (br_taken) begin
                    ex_next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ex_load = 1'b1;
                    default: ex_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                ex_ea = rs1_v + imm_s;
                case (funct3)
                    3'b000: begin
                        ex_store = 1'b1;
                        ex_we    = 4'b0001 << ex_ea[1:0];
                        ex_wdata = {4{rs2_v[7:0]}};
                    end
                    3'b001: begin
                        ex_store = 1'b1;
                        ex_we    = ex_ea[1] ? 4'b1100 : 4'b0011;
                        ex_wdata = {2{rs2_v[15:0]}};
                    end
                    3'b010: begin
                        ex_store = 1'b1;
                        ex_we    = 4'b1111;
                        ex_wdata = rs2_v;
                    end
                    default: ex_illegal = 1'b1;
                endcase
            end
            OP_IMM, OP_REG: begin
                ex_wr = 1'b1;
                if (opcode == OP_REG) begin
                    // Only ADD/SUB and SRL/SRA have an alternate funct7
                    if (!(funct7 == 7'b0000000 ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                        ex_illegal = 1'b1;
                    end
                end else if (funct3 == 3'b001) begin
                    if (funct7 != 7'b0000000) ex_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 != 7'b0000000 && funct7 != 7'b0100000) ex_illegal = 1'b1;
                end
                case (funct3)
                    3'b000: begin
                        if (opcode == OP_REG && funct7[5]) ex_result = rs1_v - op_b;
                        else                               ex_result = rs1_v + op_b;
                    end
                    3'b001:  ex_result = rs1_v << shamt;
                    3'b010:  ex_result = {31'd0, $signed(rs1_v) < $signed(op_b)};
                    3'b011:  ex_result = {31'd0, rs1_v < op_b};
                    3'b100:  ex_result = rs1_v ^ op_b;
                    3'b101: begin
                        if (funct7[5]) ex_result = 32'($signed(rs1_v) >>> shamt);
                        else           ex_result = rs1_v >> shamt;
                    end
                    3'b110:  ex_result = rs1_v | op_b;
                    default: ex_result = rs1_v & op_b;
                endcase
                if (ex_illegal) ex_wr = 1'b0;
            end
            OP_FENCE, OP_SYSTEM: begin
                ex_wr = 1'b0;
            end
            default: ex_illegal = 1'b1;
        endcase
    end

    // Load data lane selection and extension
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        ld_byte = 8'(bus.i_data_in_d >> {addr_d_q[1:0], 3'b000});
        ld_half = addr_d_q[1] ? bus.i_data_in_d[31:16] : bus.i_data_in_d[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = bus.i_data_in_d;
        endcase
    end

    // Control FSM, register file and registered bus outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= 32'd0;
            addr_d_q   <= 32'd0;
            data_out_q <= 32'd0;
            we_q       <= 4'd0;
            rd_q       <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (pc == HALT_ADDR) begin
`ifdef CPU_ILLEGAL_HALT_EN
                        state <= HALT;
`else
                        state <= FETCH;
`endif
                    end else if (bus.i_valid_i) begin
                        ir    <= bus.i_data_in_i;
                        state <= EXEC;
                    end
                end
                EXEC: begin
`ifdef CPU_ILLEGAL_HALT_EN
                    if (ex_illegal) begin
                        state <= HALT;
                    end else
`endif
                    if (ex_load) begin
                        addr_d_q <= ex_ea;
                        rd_q     <= 1'b1;
                        state    <= MEM;
                    end else if (ex_store) begin
                        addr_d_q   <= ex_ea;
                        we_q       <= ex_we;
                        data_out_q <= ex_wdata;
                        state      <= MEM;
                    end else begin
                        if (ex_wr && rd != 5'd0) begin
                            regs[rd] <= ex_result;
                        end
                        pc    <= ex_next_pc;
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (bus.i_valid_d) begin
                        if (rd_q && rd != 5'd0) begin
                            regs[rd] <= ld_val;
                        end
                        rd_q  <= 1'b0;
                        we_q  <= 4'd0;
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    rd_q  <= 1'b0;
                    we_q  <= 4'd0;
                    state <= HALT;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.o_addr_i     = pc;
    assign bus.o_addr_d     = addr_d_q;
    assign bus.o_we_d       = we_q;
    assign bus.o_rd_d       = rd_q;
    assign bus.o_data_out_d = data_out_q;

endmodule

// File: tb/tb_risk_cpu.sv
// Self-checking bench for risk_cpu: small directed programs with hand-computed
// store traffic, plus reset, stall and halt sequences.
module tb_risk_cpu;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam int NV = 10;

    logic i_clk;
    logic i_rst;
    risk_cpu_if bus();

    risk_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction encoders
    function automatic logic [31:0] ei(input int imm, input int rs1, input logic [2:0] f3,
                                       input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] es(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), f3, t[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), f3, t[4:1], t[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] ej(input int imm, input int rd);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] eu(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] t;
        t = imm20;
        return {t[19:0], 5'(rd), op};
    endfunction
    function automatic logic [31:0] er(input logic [6:0] f7, input int rs2, input int rs1,
                                       input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    // Jump from addr to the halt address; fills all memory outside the program
    function automatic logic [31:0] halt_jump(input logic [31:0] addr);
        return ej(int'(32'h0001_0000 - addr), 0);
    endfunction

    // Instruction memory: 16-word program area, everything else jumps to halt
    logic [31:0] prog [16];
    logic        valid_i;
    logic        valid_d;
    assign bus.i_valid_i   = valid_i;
    assign bus.i_valid_d   = valid_d;
    assign bus.i_data_in_i = (bus.o_addr_i < 32'd64) ? prog[bus.o_addr_i[5:2]] : halt_jump(bus.o_addr_i);

    // Data memory with store log
    logic [31:0] dmem [64];
    logic        mem_clr;
    int          n_st;
    int          excl_bad;
    logic [31:0] log_a  [4];
    logic [31:0] log_d  [4];
    logic [3:0]  log_we [4];
    assign bus.i_data_in_d = dmem[bus.o_addr_d[7:2]];

    initial excl_bad = 0;

    always @(posedge i_clk) begin
        if (bus.o_we_d != 4'd0 && bus.o_rd_d) excl_bad <= excl_bad + 1;
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
            n_st <= 0;
        end else if (bus.o_we_d != 4'd0 && valid_d) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_we_d[b]) dmem[bus.o_addr_d[7:2]][8*b +: 8] <= bus.o_data_out_d[8*b +: 8];
            end
            if (n_st < 4) begin
                log_a[n_st]  <= bus.o_addr_d;
                log_d[n_st]  <= bus.o_data_out_d;
                log_we[n_st] <= bus.o_we_d;
            end
            n_st <= n_st + 1;
        end
    end

    // Vector table
    typedef struct {
        string              name;
        int                 n_code;
        logic [15:0][31:0]  code;
        int                 n_st;
        logic [1:0][31:0]   a;
        logic [1:0][3:0]    we;
        logic [1:0][31:0]   d;
    } vec_t;
    vec_t vecs [NV];

    int n_err;
    int n_chk;

    task automatic add(input int v, input logic [31:0] w);
        vecs[v].code[vecs[v].n_code] = w;
        vecs[v].n_code++;
    endtask
    task automatic expst(input int v, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        vecs[v].a[vecs[v].n_st]  = a;
        vecs[v].we[vecs[v].n_st] = we;
        vecs[v].d[vecs[v].n_st]  = d;
        vecs[v].n_st++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_prog(input int v);
        for (int i = 0; i < 16; i++) begin
            prog[i] = (i < vecs[v].n_code) ? vecs[v].code[i] : halt_jump(32'(i * 4));
        end
    endtask

    task automatic do_reset();
        i_rst   = 1'b0;
        mem_clr = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst   = 1'b1;
        mem_clr = 1'b0;
    endtask

    task automatic run_to_halt(input string nm);
        int cyc;
        cyc = 0;
        while (bus.o_addr_i !== 32'h0001_0000 && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
        end
        check({nm, " halt_addr"}, bus.o_addr_i, 32'h0001_0000);
    endtask

    task automatic build_vectors();
        for (int v = 0; v < NV; v++) begin
            vecs[v].n_code = 0;
            vecs[v].n_st   = 0;
            vecs[v].code   = '0;
            vecs[v].a      = '0;
            vecs[v].we     = '0;
            vecs[v].d      = '0;
        end
        // 0: ADDI/ADD/SW
        vecs[0].name = "addi_add_sw";
        add(0, ei(5, 0, 3'b000, 1, OP_IMM));
        add(0, ei(-3, 0, 3'b000, 2, OP_IMM));
        add(0, er(7'd0, 2, 1, 3'b000, 3));
        add(0, es(32'h100, 3, 0, 3'b010));
        expst(0, 32'h100, 4'b1111, 32'h0000_0002);
        // 1: XOR/OR/AND/SLL (shift uses low 5 bits of 0x33)
        vecs[1].name = "logic_sll";
        add(1, ei(32'h5A, 0, 3'b000, 1, OP_IMM));
        add(1, ei(32'h33, 0, 3'b000, 2, OP_IMM));
        add(1, er(7'd0, 2, 1, 3'b100, 3));
        add(1, er(7'd0, 2, 1, 3'b110, 4));
        add(1, er(7'd0, 2, 1, 3'b111, 5));
        add(1, er(7'd0, 2, 1, 3'b001, 6));
        add(1, er(7'd0, 4, 3, 3'b000, 7));
        add(1, er(7'd0, 5, 7, 3'b000, 7));
        add(1, es(32'h100, 7, 0, 3'b010));
        add(1, es(32'h104, 6, 0, 3'b010));
        expst(1, 32'h100, 4'b1111, 32'h0000_00F6);
        expst(1, 32'h104, 4'b1111, 32'h02D0_0000);
        // 2: SB then LB sign-extends
        vecs[2].name = "sb_lb";
        add(2, ei(32'hAB, 0, 3'b000, 1, OP_IMM));
        add(2, es(32'h103, 1, 0, 3'b000));
        add(2, ei(32'h103, 0, 3'b000, 4, OP_LOAD));
        add(2, es(32'h104, 4, 0, 3'b010));
        expst(2, 32'h103, 4'b1000, 32'hABAB_ABAB);
        expst(2, 32'h104, 4'b1111, 32'hFFFF_FFAB);
        // 3: SB then LBU zero-extends
        vecs[3].name = "sb_lbu";
        add(3, ei(32'hAB, 0, 3'b000, 1, OP_IMM));
        add(3, es(32'h103, 1, 0, 3'b000));
        add(3, ei(32'h103, 0, 3'b100, 4, OP_LOAD));
        add(3, es(32'h104, 4, 0, 3'b010));
        expst(3, 32'h103, 4'b1000, 32'hABAB_ABAB);
        expst(3, 32'h104, 4'b1111, 32'h0000_00AB);
        // 4: branches with x1=-1, x2=1
        vecs[4].name = "branches";
        add(4, ei(-1, 0, 3'b000, 1, OP_IMM));
        add(4, ei(1, 0, 3'b000, 2, OP_IMM));
        add(4, eb(8, 2, 1, 3'b100));
        add(4, ei(1, 0, 3'b000, 3, OP_IMM));
        add(4, eb(8, 2, 1, 3'b110));
        add(4, ei(2, 3, 3'b000, 3, OP_IMM));
        add(4, eb(8, 2, 1, 3'b001));
        add(4, ei(4, 3, 3'b000, 3, OP_IMM));
        add(4, es(32'h100, 3, 0, 3'b010));
        add(4, eb(8, 2, 1, 3'b111));
        add(4, ei(8, 3, 3'b000, 3, OP_IMM));
        add(4, eb(8, 2, 1, 3'b101));
        add(4, ei(16, 3, 3'b000, 3, OP_IMM));
        add(4, es(32'h104, 3, 0, 3'b010));
        expst(4, 32'h100, 4'b1111, 32'h0000_0002);
        expst(4, 32'h104, 4'b1111, 32'h0000_0012);
        // 5: x0 write discarded; JAL x5,+8 at 0x20
        vecs[5].name = "jal_x0";
        add(5, ei(7, 0, 3'b000, 0, OP_IMM));
        for (int i = 0; i < 7; i++) add(5, 32'h0000_0013);
        add(5, ej(8, 5));
        add(5, ei(32'h7FF, 0, 3'b000, 5, OP_IMM));
        add(5, es(32'h10C, 5, 0, 3'b010));
        add(5, es(32'h110, 0, 0, 3'b010));
        expst(5, 32'h10C, 4'b1111, 32'h0000_0024);
        expst(5, 32'h110, 4'b1111, 32'h0000_0000);
        // 6: LUI/XORI/SRAI/SRLI/SUB
        vecs[6].name = "lui_shifts";
        add(6, eu(32'h12345, 1, OP_LUI));
        add(6, ei(32'h678, 1, 3'b000, 1, OP_IMM));
        add(6, ei(-1, 1, 3'b100, 2, OP_IMM));
        add(6, ei(32'h404, 2, 3'b101, 3, OP_IMM));
        add(6, ei(4, 2, 3'b101, 4, OP_IMM));
        add(6, er(7'b0100000, 3, 4, 3'b000, 5));
        add(6, es(32'h100, 3, 0, 3'b010));
        add(6, es(32'h104, 5, 0, 3'b010));
        expst(6, 32'h100, 4'b1111, 32'hFEDC_BA98);
        expst(6, 32'h104, 4'b1111, 32'h1000_0000);
        // 7: SH upper half, LHU, SLT vs SLTU
        vecs[7].name = "sh_lhu_slt";
        add(7, ei(-2, 0, 3'b000, 1, OP_IMM));
        add(7, es(32'h102, 1, 0, 3'b001));
        add(7, ei(32'h102, 0, 3'b101, 2, OP_LOAD));
        add(7, er(7'd0, 0, 1, 3'b010, 3));
        add(7, er(7'd0, 0, 1, 3'b011, 4));
        add(7, er(7'd0, 3, 2, 3'b000, 5));
        add(7, er(7'd0, 4, 5, 3'b000, 5));
        add(7, es(32'h104, 5, 0, 3'b010));
        expst(7, 32'h102, 4'b1100, 32'hFFFE_FFFE);
        expst(7, 32'h104, 4'b1111, 32'h0000_FFFF);
        // 8: AUIPC, JALR clears bit0, BNE taken
        vecs[8].name = "auipc_jalr";
        add(8, eu(0, 1, OP_AUIPC));
        add(8, ei(32'h11, 1, 3'b000, 2, OP_JALR));
        add(8, ei(0, 0, 3'b000, 2, OP_IMM));
        add(8, ei(0, 0, 3'b000, 2, OP_IMM));
        add(8, eb(8, 0, 2, 3'b001));
        add(8, ei(0, 0, 3'b000, 2, OP_IMM));
        add(8, es(32'h100, 2, 0, 3'b010));
        add(8, eu(1, 3, OP_AUIPC));
        add(8, es(32'h104, 3, 0, 3'b010));
        expst(8, 32'h100, 4'b1111, 32'h0000_0008);
        expst(8, 32'h104, 4'b1111, 32'h0000_101C);
        // 9: illegal word and ECALL run as NOPs
        vecs[9].name = "illegal_nop";
        add(9, ei(9, 0, 3'b000, 1, OP_IMM));
        add(9, 32'hFFFF_FFFF);
        add(9, 32'h0000_0073);
        add(9, ei(1, 1, 3'b000, 1, OP_IMM));
        add(9, es(32'h100, 1, 0, 3'b010));
        expst(9, 32'h100, 4'b1111, 32'h0000_000A);
    endtask

    initial begin
        n_err   = 0;
        n_chk   = 0;
        mem_clr = 1'b1;
        valid_i = 1'b1;
        valid_d = 1'b1;
        i_rst   = 1'b0;
        build_vectors();
        load_prog(0);

        // Reset values, then first fetch advances after two cycles
        @(negedge i_clk);
        check("rst o_addr_i", bus.o_addr_i, 32'h0);
        check("rst o_we_d", 32'(bus.o_we_d), 32'h0);
        check("rst o_rd_d", 32'(bus.o_rd_d), 32'h0);
        check("rst o_addr_d", bus.o_addr_d, 32'h0);
        check("rst o_data_out_d", bus.o_data_out_d, 32'h0);
        @(negedge i_clk);
        i_rst   = 1'b1;
        mem_clr = 1'b0;
        @(negedge i_clk);
        check("fetch pc0", bus.o_addr_i, 32'h0);
        @(negedge i_clk);
        check("fetch pc4", bus.o_addr_i, 32'h4);

        // Table-driven program runs
        for (int v = 0; v < NV; v++) begin
            load_prog(v);
            valid_i = 1'b1;
            valid_d = 1'b1;
            do_reset();
            run_to_halt(vecs[v].name);
            check($sformatf("%s n_stores", vecs[v].name), 32'(n_st), 32'(vecs[v].n_st));
            for (int s = 0; s < vecs[v].n_st; s++) begin
                check($sformatf("%s st%0d addr", vecs[v].name, s), log_a[s], vecs[v].a[s]);
                check($sformatf("%s st%0d we", vecs[v].name, s), 32'(log_we[s]), 32'(vecs[v].we[s]));
                check($sformatf("%s st%0d data", vecs[v].name, s), log_d[s], vecs[v].d[s]);
            end
        end

        // Core stays parked at the halt address
        repeat (5) @(negedge i_clk);
        check("halt hold addr", bus.o_addr_i, 32'h0001_0000);
        check("halt hold rd", 32'(bus.o_rd_d), 32'h0);
        check("halt hold we", 32'(bus.o_we_d), 32'h0);

        // Fetch stall then store stall
        load_prog(0);
        valid_i = 1'b0;
        valid_d = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check($sformatf("stall fetch addr c%0d", k), bus.o_addr_i, 32'h0);
        end
        valid_i = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (bus.o_we_d == 4'd0 && cyc < 200) begin
                @(negedge i_clk);
                cyc++;
            end
        end
        check("stall st we", 32'(bus.o_we_d), 32'hF);
        check("stall st addr", bus.o_addr_d, 32'h100);
        check("stall st data", bus.o_data_out_d, 32'h2);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            check($sformatf("stall we held c%0d", k), 32'(bus.o_we_d), 32'hF);
        end
        valid_d = 1'b1;
        @(negedge i_clk);
        check("stall we cleared", 32'(bus.o_we_d), 32'h0);
        run_to_halt("stall");
        check("stall n_stores", 32'(n_st), 32'd1);

        check("rd_we exclusive", 32'(excl_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/risk_cpu.md
Name: risk_cpu

Overview:
- Multi-cycle, non-pipelined RV32I integer core.
- Separate instruction and data memory ports; no caches.
- Sits between instruction memory and data memory. Each is a zero-wait synchronous memory qualified by a valid input.
- Executes from reset vector 0x00000000. The system halts when the fetch address reaches 0x00010000.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_valid_i  in  1  instruction read data valid this cycle.
- i_valid_d  in  1  data access completes this cycle.
- i_data_in_i  in  32  instruction word for o_addr_i.
- i_data_in_d  in  32  load data word for o_addr_d, aligned word, all lanes.
- o_addr_i  out  32  fetch address; equals PC.
- o_addr_d  out  32  data byte address.
- o_we_d  out  4  store byte-lane enables; bit n = bits [8n+7:8n].
- o_rd_d  out  1  load request.
- o_data_out_d  out  32  store data, lane-aligned.

Behaviour:
- Reset (i_rst=0, async):
  - PC=RESET_PC; state=FETCH.
  - o_we_d=0, o_rd_d=0, o_addr_d=0, o_data_out_d=0.
  - x1..x31 cleared to 0.
- x0 always reads 0; writes to x0 are discarded.
- FSM states: FETCH, EXEC, MEM, HALT.
- FETCH:
  - o_addr_i=PC, held stable.
  - On a rising edge with i_valid_i=1: latch i_data_in_i into IR, go to EXEC.
  - Otherwise stay in FETCH.
- EXEC:
  - Decode IR; read rs1/rs2; compute ALU result or effective address.
  - Non-memory instructions: write rd, update PC, go to FETCH. These take 2 cycles total.
  - Loads/stores: register o_addr_d=rs1+imm; for stores register o_we_d and o_data_out_d; go to MEM.
- MEM:
  - Load: o_rd_d=1. On the edge with i_valid_d=1, extract/extend the selected bytes, write rd, PC+=4, clear o_rd_d, go to FETCH.
  - Store: o_we_d is held until the edge with i_valid_d=1, then cleared, PC+=4, go to FETCH.
  - o_rd_d and o_we_d are never both nonzero.
- Instruction set:
  - LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
  - FENCE, ECALL, EBREAK execute as NOP (PC+=4).
- JALR target: (rs1+imm) with bit0 cleared. rd = PC+4, written using the old PC.
- Branch target: PC+imm. Not-taken: PC+4.
- Arithmetic:
  - 32-bit wraparound, no overflow detection.
  - Shifts use the low 5 bits of the shift amount.
  - SLT is signed, SLTU unsigned.
- Byte lanes:
  - Byte: lane = addr[1:0].
  - Halfword: lanes {addr[1],0}/{addr[1],1}; addr[0] ignored.
  - Word: all lanes; addr[1:0] ignored.
  - SB replicates rs2[7:0] to all 4 bytes; SH replicates rs2[15:0] to both halves.
- Unaligned PC targets: the PC is used as-is; no trap.
- Illegal opcode: behaviour per the optional feature below.

Optional Feature:
- Macro: CPU_ILLEGAL_HALT_EN.
- Defined: an unrecognised opcode or funct field enters HALT. In HALT, o_addr_i holds the faulting PC, o_rd_d=0, o_we_d=0, and the core stays there until reset.
- Not defined: an illegal instruction executes as NOP (PC+=4) and HALT is unreachable.

Test Plan:
- Reset then release, memory always valid: o_addr_i=0x0 then 0x4 two cycles later. During reset o_we_d=0 and o_rd_d=0.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SW x3,0x100(x0):
  - one write at o_addr_d=0x100, o_we_d=4'b1111, o_data_out_d=0x00000002.
- SB x1,0x103(x0) with x1=0x000000AB:
  - o_we_d=4'b1000, o_data_out_d=0xABABABAB.
  - Then LB x4,0x103(x0), SW x4,0x104(x0) stores 0xFFFFFFAB; LBU stores 0x000000AB.
- BNE/BLT/BLTU with x1=-1, x2=1:
  - BLT taken, BLTU not taken.
  - JAL x5,+8 at PC 0x20: next fetch 0x28, x5=0x24.
- Hold i_valid_i=0 for 3 cycles during FETCH, then i_valid_d=0 for 2 cycles during a store:
  - o_addr_i held stable; o_we_d held until the valid cycle; exactly one write.
- Program ending with JAL to 0x00010000: o_addr_i reaches 0x00010000. ADDI x0,x0,7 leaves x0=0.
